// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: default widths, opcode encodings
// and field-position helpers used by the address selector and the pipeline.
package decode_pkg;

    localparam int DEF_IW    = 20;
    localparam int DEF_OPW   = 4;
    localparam int DEF_RAW   = 4;
    localparam int DEF_CNT_W = 16;

    localparam logic [DEF_OPW-1:0] STORE_OP = 4'b1100;
    localparam logic [DEF_OPW-1:0] LOAD_OP  = 4'b1101;

    // Fields sit directly below the opcode, in the order rd, rs1, rs2.
    function automatic int opcode_lsb(int iw, int opw);
        return iw - opw;
    endfunction

    function automatic int rd_lsb(int iw, int opw, int raw);
        return iw - opw - raw;
    endfunction

    function automatic int rs1_lsb(int iw, int opw, int raw);
        return iw - opw - 2 * raw;
    endfunction

    function automatic int rs2_lsb(int iw, int opw, int raw);
        return iw - opw - 3 * raw;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle. The slave modport is
// the decode stage's view; master is the surrounding fetch/execute environment.
interface decode_stage_pipe_if #(
    parameter int IW  = decode_pkg::DEF_IW,
    parameter int RAW = decode_pkg::DEF_RAW
);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instruction;
    logic          flush;
    logic          out_ready;

    logic           out_valid;
    logic [IW-1:0]  out_instruction;
    logic [RAW-1:0] out_addr1;
    logic [RAW-1:0] out_addr2;
    logic [RAW-1:0] out_dest;
    logic           out_is_store;
    logic           out_is_load;

    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, out_instruction, out_addr1, out_addr2,
               out_dest, out_is_store, out_is_load
    );

    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, out_instruction, out_addr1, out_addr2,
               out_dest, out_is_store, out_is_load
    );

endinterface

// File: rtl/decode_addr_sel.sv
// Combinational opcode decode and register-file read-address mux; stores read
// rd (data) and rs1 (base), everything else reads rs1 and rs2.
module decode_addr_sel #(
    parameter int                IW       = decode_pkg::DEF_IW,
    parameter int                OPW      = decode_pkg::DEF_OPW,
    parameter int                RAW      = decode_pkg::DEF_RAW,
    parameter logic [OPW-1:0]    STORE_OP = decode_pkg::STORE_OP,
    parameter logic [OPW-1:0]    LOAD_OP  = decode_pkg::LOAD_OP
) (
    input  logic [IW-1:0]  instruction,
    output logic [RAW-1:0] addr1,
    output logic [RAW-1:0] addr2,
    output logic [RAW-1:0] dest,
    output logic           is_store,
    output logic           is_load
);

    localparam int OP_LSB  = decode_pkg::opcode_lsb(IW, OPW);
    localparam int RD_LSB  = decode_pkg::rd_lsb(IW, OPW, RAW);
    localparam int RS1_LSB = decode_pkg::rs1_lsb(IW, OPW, RAW);
    localparam int RS2_LSB = decode_pkg::rs2_lsb(IW, OPW, RAW);

    logic [OPW-1:0] opcode;
    logic [RAW-1:0] rd_f;
    logic [RAW-1:0] rs1_f;
    logic [RAW-1:0] rs2_f;

    assign opcode = instruction[OP_LSB +: OPW];
    assign rd_f   = instruction[RD_LSB +: RAW];
    assign rs1_f  = instruction[RS1_LSB +: RAW];
    assign rs2_f  = instruction[RS2_LSB +: RAW];

    // NOTE: every output of an always_comb gets a value on every path (here via
    // defaults first), otherwise synthesis infers a latch.
    always_comb begin
        addr1    = rs1_f;
        addr2    = rs2_f;
        is_store = (opcode == STORE_OP);
        is_load  = (opcode == LOAD_OP);
        if (is_store) begin
            addr1 = rd_f;
            addr2 = rs1_f;
        end
    end

    assign dest = rd_f;

    // Immediate/unused low bits below rs2 are intentionally not decoded here.
    generate
        if (RS2_LSB > 0) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^instruction[RS2_LSB-1:0];
        end
    endgenerate

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: drives RF read addresses combinationally and holds
// the decoded instruction in the ID/EX register with load-use bubble insertion.
module decode_stage_pipe #(
    parameter int                IW       = decode_pkg::DEF_IW,
    parameter int                OPW      = decode_pkg::DEF_OPW,
    parameter int                RAW      = decode_pkg::DEF_RAW,
    parameter logic [OPW-1:0]    STORE_OP = decode_pkg::STORE_OP,
    parameter logic [OPW-1:0]    LOAD_OP  = decode_pkg::LOAD_OP,
    parameter int                CNT_W    = decode_pkg::DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    decode_stage_pipe_if.slave   bus,
    output logic [RAW-1:0]       rf_addr1,
    output logic [RAW-1:0]       rf_addr2,
    output logic                 hazard,
    output logic [CNT_W-1:0]     bubble_count
);

    logic [RAW-1:0] sel_addr1;
    logic [RAW-1:0] sel_addr2;
    logic [RAW-1:0] sel_dest;
    logic           sel_is_store;
    logic           sel_is_load;

    decode_addr_sel #(
        .IW       (IW),
        .OPW      (OPW),
        .RAW      (RAW),
        .STORE_OP (STORE_OP),
        .LOAD_OP  (LOAD_OP)
    ) u_addr_sel (
        .instruction (bus.instruction),
        .addr1       (sel_addr1),
        .addr2       (sel_addr2),
        .dest        (sel_dest),
        .is_store    (sel_is_store),
        .is_load     (sel_is_load)
    );

    logic             valid_q,     valid_d;
    logic [IW-1:0]    instr_q,     instr_d;
    logic [RAW-1:0]   addr1_q,     addr1_d;
    logic [RAW-1:0]   addr2_q,     addr2_d;
    logic [RAW-1:0]   dest_q,      dest_d;
    logic             is_store_q,  is_store_d;
    logic             is_load_q,   is_load_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic slot_free;
    logic accept;

    assign rf_addr1 = sel_addr1;
    assign rf_addr2 = sel_addr2;

    assign slot_free = !valid_q || bus.out_ready;

    // A load in ID/EX whose rd feeds either read port of the incoming instruction.
    assign hazard = bus.in_valid && valid_q && is_load_q && !is_store_q &&
                    ((sel_addr1 == dest_q) || (sel_addr2 == dest_q));

    assign bus.in_ready = slot_free && !hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        dest_d       = dest_q;
        is_store_d   = is_store_q;
        is_load_d    = is_load_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            instr_d    = bus.instruction;
            addr1_d    = sel_addr1;
            addr2_d    = sel_addr2;
            dest_d     = sel_dest;
            is_store_d = sel_is_store;
            is_load_d  = sel_is_load;
        end else if (slot_free && hazard) begin
            valid_d = 1'b0;
            if (!(&bubble_cnt_q)) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values. The payload fields are reset as well as valid so that
    // out_* read as zero after reset rather than stale contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            dest_q       <= '0;
            is_store_q   <= 1'b0;
            is_load_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            dest_q       <= dest_d;
            is_store_q   <= is_store_d;
            is_load_q    <= is_load_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_instruction = instr_q;
    assign bus.out_addr1       = addr1_q;
    assign bus.out_addr2       = addr2_q;
    assign bus.out_dest        = dest_q;
    assign bus.out_is_store    = is_store_q;
    assign bus.out_is_load     = is_load_q;
    assign bubble_count        = bubble_cnt_q;

endmodule
